// File: rtl/proc_io_pkg.sv
// Shared types for the proc I/O bridge: event records queued toward the
// processor and the state encodings of the TX and interrupt FSMs.
package proc_io_pkg;

  typedef enum logic {
    EVT_KEY = 1'b0,
    EVT_ETH = 1'b1
  } evt_type_e;

  typedef struct packed {
    evt_type_e   etype;
    logic [31:0] data;
  } evt_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [1:0] {
    INT_IDLE,
    INT_FIRE,
    INT_HOLD
  } int_state_e;

endpackage

// File: rtl/proc_io_evt_fifo.sv
// Synchronous FIFO of event records between the inbound collectors and the
// interrupt FSM. A write while full is accepted only if a read frees a slot.
module proc_io_evt_fifo
  import proc_io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  evt_t wr_data,
  input  logic rd_en,
  output evt_t rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  evt_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_wr;
  logic           do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/proc_io_bridge.sv
// Peripheral side of the proc I/O interface: Ethernet TX/RX, PPU hand-off,
// key capture and interrupt delivery. PROC_IO_BRIDGE_DROP_CNT_EN adds drop_count.
module proc_io_bridge
  import proc_io_pkg::*;
#(
  parameter int EVT_DEPTH   = 4,
  parameter int INT_HOLDOFF = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd,
  input  logic        ppu_send,
  input  logic [31:0] interface_data,
  output logic [7:0]  eth_tx_data,
  output logic        eth_tx_valid,
  input  logic        eth_tx_ready,
  output logic        tx_busy,
  output logic        tx_overrun,
  output logic [31:0] ppu_data,
  output logic        ppu_valid,
  input  logic        ppu_ready,
  input  logic [7:0]  eth_rx_data,
  input  logic        eth_rx_valid,
  input  logic        key_event,
  input  logic [7:0]  key_code,
  output logic        interrupt_key,
  output logic        interrupt_eth,
  output logic [31:0] interrupt_source_data
`ifdef PROC_IO_BRIDGE_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int HOLD_W = $clog2(INT_HOLDOFF + 1);

  tx_state_e         tx_state;
  logic [31:0]       tx_word;
  logic [1:0]        tx_idx;
  logic [23:0]       rx_shift;
  logic [1:0]        rx_cnt;
  logic              eth_evt;
  logic              key_pend_valid;
  logic [7:0]        key_pend_code;
  logic              key_drain;
  logic              key_drop;
  evt_t              fifo_wdata;
  evt_t              fifo_head;
  logic              fifo_wr;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  int_state_e        int_state;
  logic [HOLD_W-1:0] hold_cnt;

  // The outgoing byte is always the top of a left-shifting word register.
  assign eth_tx_data = tx_word[31:24];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state     <= TX_IDLE;
      tx_word      <= '0;
      tx_idx       <= '0;
      tx_busy      <= 1'b0;
      eth_tx_valid <= 1'b0;
      tx_overrun   <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (snd) begin
            tx_word      <= interface_data;
            tx_idx       <= '0;
            tx_busy      <= 1'b1;
            eth_tx_valid <= 1'b1;
            tx_state     <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (snd) tx_overrun <= 1'b1;
          if (eth_tx_ready) begin
            tx_word <= {tx_word[23:0], 8'h00};
            tx_idx  <= tx_idx + 2'd1;
            if (tx_idx == 2'd3) begin
              tx_busy      <= 1'b0;
              eth_tx_valid <= 1'b0;
              tx_state     <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppu_valid <= 1'b0;
      ppu_data  <= '0;
    end else if (ppu_valid) begin
      if (ppu_ready) ppu_valid <= 1'b0;
    end else if (ppu_send) begin
      ppu_valid <= 1'b1;
      ppu_data  <= interface_data;
    end
  end

  assign eth_evt = eth_rx_valid && (rx_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      rx_cnt   <= '0;
    end else if (eth_rx_valid) begin
      rx_shift <= {rx_shift[15:0], eth_rx_data};
      rx_cnt   <= rx_cnt + 2'd1;
    end
  end

  // Pending key leaves only when the FIFO can really take it, so a blocked
  // key keeps its slot and later keys are the ones dropped.
  assign key_drain = key_pend_valid && !eth_evt && (!fifo_full || fifo_pop);
  assign key_drop  = key_event && key_pend_valid && !key_drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_pend_valid <= 1'b0;
      key_pend_code  <= '0;
    end else if (key_event && !key_drop) begin
      key_pend_valid <= 1'b1;
      key_pend_code  <= key_code;
    end else if (key_drain) begin
      key_pend_valid <= 1'b0;
    end
  end

  always_comb begin
    fifo_wr          = eth_evt || key_drain;
    fifo_wdata.etype = EVT_KEY;
    fifo_wdata.data  = {24'h0, key_pend_code};
    if (eth_evt) begin
      fifo_wdata.etype = EVT_ETH;
      fifo_wdata.data  = {rx_shift, eth_rx_data};
    end
  end

  assign fifo_pop = (int_state == INT_IDLE) && !fifo_empty;

  proc_io_evt_fifo #(
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The pop happens on the IDLE->FIRE edge so the registered pulse is visible
  // during FIRE, two cycles after the event that filled an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_state             <= INT_IDLE;
      hold_cnt              <= '0;
      interrupt_key         <= 1'b0;
      interrupt_eth         <= 1'b0;
      interrupt_source_data <= '0;
    end else begin
      case (int_state)
        INT_IDLE: begin
          if (!fifo_empty) begin
            interrupt_source_data <= fifo_head.data;
            interrupt_key         <= (fifo_head.etype == EVT_KEY);
            interrupt_eth         <= (fifo_head.etype == EVT_ETH);
            int_state             <= INT_FIRE;
          end
        end
        INT_FIRE: begin
          interrupt_key <= 1'b0;
          interrupt_eth <= 1'b0;
          hold_cnt      <= '0;
          int_state     <= INT_HOLD;
        end
        INT_HOLD: begin
          if (hold_cnt == HOLD_W'(INT_HOLDOFF - 1)) int_state <= INT_IDLE;
          else hold_cnt <= hold_cnt + 1'b1;
        end
        default: int_state <= INT_IDLE;
      endcase
    end
  end

`ifdef PROC_IO_BRIDGE_DROP_CNT_EN
  logic        eth_drop;
  logic [16:0] drop_sum;

  assign eth_drop = eth_evt && fifo_full && !fifo_pop;
  assign drop_sum = {1'b0, drop_count} + 17'(eth_drop) + 17'(key_drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_count <= '0;
    else drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_proc_io_bridge.sv
// Directed self-checking bench for proc_io_bridge; one task per scenario.
module tb_proc_io_bridge;

  localparam int EVT_DEPTH   = 4;
  localparam int INT_HOLDOFF = 16;

  logic        clk;
  logic        rst_n;
  logic        snd;
  logic        ppu_send;
  logic [31:0] interface_data;
  logic [7:0]  eth_tx_data;
  logic        eth_tx_valid;
  logic        eth_tx_ready;
  logic        tx_busy;
  logic        tx_overrun;
  logic [31:0] ppu_data;
  logic        ppu_valid;
  logic        ppu_ready;
  logic [7:0]  eth_rx_data;
  logic        eth_rx_valid;
  logic        key_event;
  logic [7:0]  key_code;
  logic        interrupt_key;
  logic        interrupt_eth;
  logic [31:0] interrupt_source_data;
`ifdef PROC_IO_BRIDGE_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  int n_checks;
  int n_fail;

  proc_io_bridge #(
    .EVT_DEPTH   (EVT_DEPTH),
    .INT_HOLDOFF (INT_HOLDOFF)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .snd                   (snd),
    .ppu_send              (ppu_send),
    .interface_data        (interface_data),
    .eth_tx_data           (eth_tx_data),
    .eth_tx_valid          (eth_tx_valid),
    .eth_tx_ready          (eth_tx_ready),
    .tx_busy               (tx_busy),
    .tx_overrun            (tx_overrun),
    .ppu_data              (ppu_data),
    .ppu_valid             (ppu_valid),
    .ppu_ready             (ppu_ready),
    .eth_rx_data           (eth_rx_data),
    .eth_rx_valid          (eth_rx_valid),
    .key_event             (key_event),
    .key_code              (key_code),
    .interrupt_key         (interrupt_key),
    .interrupt_eth         (interrupt_eth),
    .interrupt_source_data (interrupt_source_data)
`ifdef PROC_IO_BRIDGE_DROP_CNT_EN
    ,
    .drop_count            (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    repeat (INT_HOLDOFF + 6) step();
  endtask

  task automatic wait_int(input int limit, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < limit) begin
      step();
      cycles++;
      if (interrupt_key || interrupt_eth) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({eth_tx_data, eth_tx_valid, tx_busy, tx_overrun, ppu_data, ppu_valid,
         interrupt_key, interrupt_eth, interrupt_source_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got nonzero outputs tx=%h v=%b busy=%b ovr=%b ppu=%h pv=%b ik=%b ie=%b isd=%h, required all 0",
               eth_tx_data, eth_tx_valid, tx_busy, tx_overrun, ppu_data, ppu_valid,
               interrupt_key, interrupt_eth, interrupt_source_data);
    end
`ifdef PROC_IO_BRIDGE_DROP_CNT_EN
    n_checks++;
    if (drop_count !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_drop_count: got %h required 0000", drop_count);
    end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_tx();
    int extra;
    snd = 1'b1; interface_data = 32'hDEADBEEF; eth_tx_ready = 1'b0;
    step();
    snd = 1'b0;
    n_checks++;
    if ({tx_busy, eth_tx_valid, eth_tx_data} !== {1'b1, 1'b1, 8'hDE}) begin
      n_fail++;
      $display("[TB] FAIL tx_byte0: got busy=%b valid=%b data=%h required 1 1 de", tx_busy, eth_tx_valid, eth_tx_data);
    end
    step();
    n_checks++;
    if ({eth_tx_valid, eth_tx_data} !== {1'b1, 8'hDE}) begin
      n_fail++;
      $display("[TB] FAIL tx_stall_hold: got valid=%b data=%h required 1 de", eth_tx_valid, eth_tx_data);
    end
    eth_tx_ready = 1'b1; snd = 1'b1; interface_data = 32'h11223344;
    step();
    snd = 1'b0;
    n_checks++;
    if (eth_tx_data !== 8'hAD) begin
      n_fail++;
      $display("[TB] FAIL tx_byte1: got %h required ad", eth_tx_data);
    end
    n_checks++;
    if (tx_overrun !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL tx_overrun: got %b required 1", tx_overrun);
    end
    step();
    n_checks++;
    if (eth_tx_data !== 8'hBE) begin
      n_fail++;
      $display("[TB] FAIL tx_byte2: got %h required be", eth_tx_data);
    end
    step();
    n_checks++;
    if ({tx_busy, eth_tx_data} !== {1'b1, 8'hEF}) begin
      n_fail++;
      $display("[TB] FAIL tx_byte3: got busy=%b data=%h required 1 ef", tx_busy, eth_tx_data);
    end
    step();
    n_checks++;
    if ({tx_busy, eth_tx_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL tx_done: got busy=%b valid=%b required 0 0", tx_busy, eth_tx_valid);
    end
    extra = 0;
    repeat (6) begin
      step();
      if (eth_tx_valid) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("[TB] FAIL tx_no_extra: got %0d extra valid cycles required 0", extra);
    end
  endtask

  task automatic test_rx();
    logic [7:0] bytes [4];
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) begin
      eth_rx_data = bytes[i]; eth_rx_valid = 1'b1;
      step();
    end
    eth_rx_valid = 1'b0;
    n_checks++;
    if (interrupt_eth !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rx_early: got interrupt_eth=%b required 0", interrupt_eth);
    end
    step();
    n_checks++;
    if ({interrupt_eth, interrupt_key, interrupt_source_data} !== {1'b1, 1'b0, 32'h12345678}) begin
      n_fail++;
      $display("[TB] FAIL rx_pulse: got eth=%b key=%b data=%h required 1 0 12345678",
               interrupt_eth, interrupt_key, interrupt_source_data);
    end
    step();
    n_checks++;
    if ({interrupt_eth, interrupt_source_data} !== {1'b0, 32'h12345678}) begin
      n_fail++;
      $display("[TB] FAIL rx_after: got eth=%b data=%h required 0 12345678", interrupt_eth, interrupt_source_data);
    end
    idle_wait();
  endtask

  task automatic test_key_eth_collision();
    logic [7:0] bytes [4];
    int         cyc;
    bit         seen;
    bytes = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    for (int i = 0; i < 4; i++) begin
      eth_rx_data = bytes[i]; eth_rx_valid = 1'b1;
      if (i == 3) begin
        key_event = 1'b1; key_code = 8'h41;
      end
      step();
    end
    eth_rx_valid = 1'b0; key_event = 1'b0;
    step();
    n_checks++;
    if ({interrupt_eth, interrupt_key, interrupt_source_data} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      n_fail++;
      $display("[TB] FAIL coll_eth_first: got eth=%b key=%b data=%h required 1 0 cafef00d",
               interrupt_eth, interrupt_key, interrupt_source_data);
    end
    wait_int(40, cyc, seen);
    n_checks++;
    if (!seen || cyc != INT_HOLDOFF + 2) begin
      n_fail++;
      $display("[TB] FAIL coll_key_spacing: got seen=%b after %0d cycles required %0d", seen, cyc, INT_HOLDOFF + 2);
    end
    n_checks++;
    if ({interrupt_key, interrupt_eth, interrupt_source_data} !== {1'b1, 1'b0, 32'h00000041}) begin
      n_fail++;
      $display("[TB] FAIL coll_key_pulse: got key=%b eth=%b data=%h required 1 0 00000041",
               interrupt_key, interrupt_eth, interrupt_source_data);
    end
    step();
    n_checks++;
    if ({interrupt_key, interrupt_source_data} !== {1'b0, 32'h00000041}) begin
      n_fail++;
      $display("[TB] FAIL coll_key_oneshot: got key=%b data=%h required 0 00000041", interrupt_key, interrupt_source_data);
    end
    idle_wait();
  endtask

  task automatic test_key_burst();
    int          cyc;
    bit          seen;
    logic [31:0] exp;
    key_event = 1'b1; key_code = 8'h01;
    step();
    key_event = 1'b0;
    wait_int(10, cyc, seen);
    n_checks++;
    if (!seen || interrupt_source_data !== 32'h00000001) begin
      n_fail++;
      $display("[TB] FAIL burst_lead: got seen=%b data=%h required 1 00000001", seen, interrupt_source_data);
    end
    // Burst lands while the FSM sits in its holdoff window.
    for (int i = 0; i < EVT_DEPTH + 3; i++) begin
      key_event = 1'b1; key_code = 8'(8'h10 + i);
      step();
    end
    key_event = 1'b0;
    for (int d = 0; d < EVT_DEPTH + 1; d++) begin
      wait_int(40, cyc, seen);
      exp = 32'h10 + 32'(d);
      n_checks++;
      if (!seen || {interrupt_key, interrupt_source_data} !== {1'b1, exp}) begin
        n_fail++;
        $display("[TB] FAIL burst_deliver%0d: got seen=%b key=%b data=%h required 1 1 %h",
                 d, seen, interrupt_key, interrupt_source_data, exp);
      end
      n_checks++;
      if (cyc != ((d == 0) ? INT_HOLDOFF + 2 - (EVT_DEPTH + 3) : INT_HOLDOFF + 2)) begin
        n_fail++;
        $display("[TB] FAIL burst_spacing%0d: got %0d cycles required %0d", d, cyc,
                 (d == 0) ? INT_HOLDOFF + 2 - (EVT_DEPTH + 3) : INT_HOLDOFF + 2);
      end
    end
    wait_int(40, cyc, seen);
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL burst_dropped: got extra interrupt data=%h required none", interrupt_source_data);
    end
`ifdef PROC_IO_BRIDGE_DROP_CNT_EN
    n_checks++;
    if (drop_count !== 16'd2) begin
      n_fail++;
      $display("[TB] FAIL burst_drop_count: got %0d required 2", drop_count);
    end
`endif
  endtask

  task automatic test_ppu();
    ppu_send = 1'b1; interface_data = 32'hA5A5A5A5; ppu_ready = 1'b0;
    step();
    ppu_send = 1'b0;
    n_checks++;
    if ({ppu_valid, ppu_data} !== {1'b1, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("[TB] FAIL ppu_load: got valid=%b data=%h required 1 a5a5a5a5", ppu_valid, ppu_data);
    end
    for (int i = 0; i < 5; i++) begin
      ppu_send = (i == 2);
      interface_data = 32'h5A5A5A5A;
      step();
      n_checks++;
      if ({ppu_valid, ppu_data} !== {1'b1, 32'hA5A5A5A5}) begin
        n_fail++;
        $display("[TB] FAIL ppu_hold%0d: got valid=%b data=%h required 1 a5a5a5a5", i, ppu_valid, ppu_data);
      end
    end
    ppu_ready = 1'b1; ppu_send = 1'b1; interface_data = 32'h12121212;
    step();
    ppu_send = 1'b0; ppu_ready = 1'b0;
    n_checks++;
    if (ppu_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ppu_clear: got valid=%b required 0", ppu_valid);
    end
    step();
    n_checks++;
    if ({ppu_valid, ppu_data} !== {1'b0, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("[TB] FAIL ppu_no_bypass: got valid=%b data=%h required 0 a5a5a5a5", ppu_valid, ppu_data);
    end
  endtask

  task automatic test_reset_midflight();
    int cyc;
    bit seen;
    int activity;
    n_checks++;
    if (tx_overrun !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL overrun_sticky: got %b required 1", tx_overrun);
    end
    idle_wait();
    key_event = 1'b1; key_code = 8'h01;
    step();
    key_event = 1'b0;
    wait_int(10, cyc, seen);
    key_event = 1'b1; key_code = 8'h20;
    snd = 1'b1; interface_data = 32'h01020304; eth_tx_ready = 1'b1;
    ppu_send = 1'b1;
    step();
    key_code = 8'h21; snd = 1'b0; ppu_send = 1'b0;
    step();
    key_event = 1'b0;
    step();
    n_checks++;
    if ({tx_busy, eth_tx_data, ppu_valid} !== {1'b1, 8'h03, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_state: got busy=%b data=%h ppu_valid=%b required 1 03 1", tx_busy, eth_tx_data, ppu_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({eth_tx_data, eth_tx_valid, tx_busy, tx_overrun, ppu_data, ppu_valid,
         interrupt_key, interrupt_eth, interrupt_source_data} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got tx=%h v=%b busy=%b ovr=%b ppu=%h pv=%b ik=%b ie=%b isd=%h, required all 0",
               eth_tx_data, eth_tx_valid, tx_busy, tx_overrun, ppu_data, ppu_valid,
               interrupt_key, interrupt_eth, interrupt_source_data);
    end
`ifdef PROC_IO_BRIDGE_DROP_CNT_EN
    n_checks++;
    if (drop_count !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_drop_count: got %h required 0000", drop_count);
    end
`endif
    step();
    step();
    rst_n = 1'b1;
    activity = 0;
    repeat (INT_HOLDOFF + 24) begin
      step();
      if (eth_tx_valid || tx_busy || interrupt_key || interrupt_eth) activity++;
    end
    n_checks++;
    if (activity !== 0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_residue: got %0d active cycles required 0", activity);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    snd            = 1'b0;
    ppu_send       = 1'b0;
    interface_data = '0;
    eth_tx_ready   = 1'b0;
    ppu_ready      = 1'b0;
    eth_rx_data    = '0;
    eth_rx_valid   = 1'b0;
    key_event      = 1'b0;
    key_code       = '0;
    $display("[TB] starting proc_io_bridge bench");
    test_reset();
    test_tx();
    test_rx();
    test_key_eth_collision();
    test_key_burst();
    test_ppu();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
